flash_cmd_arbiter: RTL and testbench
====================================

FLASH_CMD_ARBITER -- requirements
Module: flash_cmd_arbiter
Interface
REQ-001 SHALL have parameter ADDR_W, default 16, flash command address width.
REQ-002 SHALL have parameter STARVE_MAX, default 4, max consecutive host grants while GC is waiting.
REQ-003 SHALL have parameter TIMEOUT, default 255, max cycles in ISSUE+WAIT before abort.
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port h_req  input  1  host command request.
REQ-007 SHALL have port h_we  input  1  host command is write (1) or read (0).
REQ-008 SHALL have port h_addr  input  ADDR_W  host command address.
REQ-009 SHALL have port h_wdata  input  32  host write data.
REQ-010 SHALL have port h_gnt  output  1  one-cycle host grant pulse.
REQ-011 SHALL have port h_done  output  1  one-cycle host completion pulse.
REQ-012 SHALL have port g_req  input  1  garbage-collection command request.
REQ-013 SHALL have port g_we  input  1  GC command is write.
REQ-014 SHALL have port g_addr  input  ADDR_W  GC command address.
REQ-015 SHALL have port g_wdata  input  32  GC write data.
REQ-016 SHALL have port g_gnt  output  1  one-cycle GC grant pulse.
REQ-017 SHALL have port g_done  output  1  one-cycle GC completion pulse.
REQ-018 SHALL have port rsp_rdata  output  32  read data, valid only with h_done/g_done.
REQ-019 SHALL have port rsp_err  output  1  timeout error flag, valid only with h_done/g_done.
REQ-020 SHALL have port f_valid  output  1  command valid to flash channel.
REQ-021 SHALL have port f_we  output  1  flash command write flag.
REQ-022 SHALL have port f_addr  output  ADDR_W  flash command address.
REQ-023 SHALL have port f_wdata  output  32  flash write data.
REQ-024 SHALL have port f_ready  input  1  flash accepts command when high with f_valid.
REQ-025 SHALL have port f_done  input  1  flash operation complete, one-cycle pulse.
REQ-026 SHALL have port f_rdata  input  32  flash read data, valid with f_done.
Function
REQ-027 SHALL implement FSM IDLE, ISSUE, WAIT, RESP; all outputs registered.
REQ-028 IDLE: on edge with any req high, SHALL latch winner's we/addr/wdata and owner, go ISSUE; no req -> stay IDLE.
REQ-029 Arbitration SHALL pick host if h_req, unless g_req and starve_cnt >= STARVE_MAX, or h_req low -> GC.
REQ-030 starve_cnt SHALL increment (saturating at STARVE_MAX) on each host grant while g_req high; clear on GC grant.
REQ-031 Winner's gnt SHALL be high exactly the first ISSUE cycle; req ignored outside IDLE; req still high in IDLE after done = new command.
REQ-032 ISSUE: f_valid=1, f_we/f_addr/f_wdata = latched values, stable; edge with f_ready=1 -> WAIT, f_valid=0.
REQ-033 WAIT: edge with f_done=1 -> RESP, rsp_rdata=f_rdata for read, 0 for write, rsp_err=0; f_done outside WAIT ignored.
REQ-034 Timeout counter SHALL clear on ISSUE entry, increment each ISSUE/WAIT cycle; reaching TIMEOUT -> RESP, rsp_err=1, rsp_rdata=0, f_valid=0.
REQ-035 f_done in the same cycle as timeout SHALL win: normal completion, rsp_err=0.
REQ-036 RESP: owner's done high one cycle, rsp_* valid that cycle, then IDLE; rsp_rdata/rsp_err otherwise 0.
REQ-037 Minimum latency SHALL be 3 cycles from req sampled in IDLE to done, with f_ready and f_done immediate.
Reset
REQ-038 rst SHALL force IDLE, clear starve/timeout counters, latches, all outputs to 0 immediately; in-flight command dropped, no done issued.
Verification
REQ-039 Host write addr 0x0010, data 0xDEADBEEF, f_ready=1, f_done 2 cycles later -> h_gnt 1 cycle, f_addr 0x0010, f_wdata 0xDEADBEEF, h_done once, rsp_err=0.
REQ-040 GC read addr 0x0200, f_rdata=0x12345678 on f_done -> g_done with rsp_rdata=0x12345678, rsp_err=0.
REQ-041 h_req and g_req held high, STARVE_MAX=4 -> grant order H,H,H,H,G repeating.
REQ-042 TIMEOUT=16, f_ready held 0 -> f_valid drops and done with rsp_err=1, rsp_rdata=0, 16 cycles after ISSUE entry.
REQ-043 rst asserted in WAIT -> all outputs 0, no done; after release a host read completes normally.

Source files
------------

// File: rtl/flash_cmd_arbiter.sv
// Two-requester (host / garbage-collection) arbiter for a single flash command channel.
// Host wins by default; GC is forced through after STARVE_MAX back-to-back host grants.
module flash_cmd_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned STARVE_MAX = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [31:0]       h_wdata,
  output logic              h_gnt,
  output logic              h_done,
  input  logic              g_req,
  input  logic              g_we,
  input  logic [ADDR_W-1:0] g_addr,
  input  logic [31:0]       g_wdata,
  output logic              g_gnt,
  output logic              g_done,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              f_valid,
  output logic              f_we,
  output logic [ADDR_W-1:0] f_addr,
  output logic [31:0]       f_wdata,
  input  logic              f_ready,
  input  logic              f_done,
  input  logic [31:0]       f_rdata
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 2);
  localparam int unsigned TW = $clog2(TIMEOUT + 2);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic [TW-1:0]     to_q, to_d;
  logic              owner_q, owner_d;   // 1 = GC owns the in-flight command
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              h_gnt_d, g_gnt_d, h_done_d, g_done_d, f_valid_d, rsp_err_d;
  logic [31:0]       rsp_rdata_d;
  logic              gc_win;

  // GC takes the slot when host is idle or has starved it long enough
  assign gc_win = g_req && (!h_req || (starve_q >= STARVE_LIM));

  assign f_we    = we_q;
  assign f_addr  = addr_q;
  assign f_wdata = wdata_q;

  // Next-state, counter, latch and registered-output logic
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    to_d        = to_q;
    owner_d     = owner_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = 32'd0;
    rsp_err_d   = 1'b0;
    h_gnt_d     = 1'b0;
    g_gnt_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (h_req || g_req) begin
          state_d = S_ISSUE;
          to_d    = '0;
          owner_d = gc_win;
          if (gc_win) begin
            we_d     = g_we;
            addr_d   = g_addr;
            wdata_d  = g_wdata;
            starve_d = '0;
            g_gnt_d  = 1'b1;
          end else begin
            we_d    = h_we;
            addr_d  = h_addr;
            wdata_d = h_wdata;
            h_gnt_d = 1'b1;
            if (g_req && (starve_q < STARVE_LIM)) starve_d = starve_q + SW'(1);
          end
        end
      end
      S_ISSUE: begin
        if (to_q == TO_LAST) begin
          state_d   = S_RESP;
          rsp_err_d = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
          if (f_ready) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // A completion arriving on the timeout edge still counts as success
        if (f_done) begin
          state_d     = S_RESP;
          rsp_rdata_d = we_q ? 32'd0 : f_rdata;
        end else if (to_q == TO_LAST) begin
          state_d   = S_RESP;
          rsp_err_d = 1'b1;
        end else begin
          to_d = to_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    f_valid_d = (state_d == S_ISSUE);
    h_done_d  = (state_d == S_RESP) && !owner_d;
    g_done_d  = (state_d == S_RESP) && owner_d;
  end

  // State, context latches and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      starve_q  <= '0;
      to_q      <= '0;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= 32'd0;
      h_gnt     <= 1'b0;
      g_gnt     <= 1'b0;
      h_done    <= 1'b0;
      g_done    <= 1'b0;
      f_valid   <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      starve_q  <= starve_d;
      to_q      <= to_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      h_gnt     <= h_gnt_d;
      g_gnt     <= g_gnt_d;
      h_done    <= h_done_d;
      g_done    <= g_done_d;
      f_valid   <= f_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_flash_cmd_arbiter.sv
// Scoreboard bench for flash_cmd_arbiter: expected completions are queued when
// commands are issued and retired whenever the arbiter pulses a done.
module tb_flash_cmd_arbiter;

  localparam int unsigned ADDR_W = 16;

  logic              clk, rst;
  logic              h_req, h_we, g_req, g_we;
  logic [ADDR_W-1:0] h_addr, g_addr;
  logic [31:0]       h_wdata, g_wdata;
  logic              h_gnt, h_done, g_gnt, g_done;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              f_valid, f_we;
  logic [ADDR_W-1:0] f_addr;
  logic [31:0]       f_wdata;
  logic              f_ready, f_done;
  logic [31:0]       f_rdata;

  typedef struct packed {
    logic        gc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   h_done_cnt = 0;
  int   g_done_cnt = 0;

  flash_cmd_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(4), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
    .h_gnt(h_gnt), .h_done(h_done),
    .g_req(g_req), .g_we(g_we), .g_addr(g_addr), .g_wdata(g_wdata),
    .g_gnt(g_gnt), .g_done(g_done),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .f_valid(f_valid), .f_we(f_we), .f_addr(f_addr), .f_wdata(f_wdata),
    .f_ready(f_ready), .f_done(f_done), .f_rdata(f_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one cycle, sample 1ns after the edge and retire any completion
  task automatic tick;
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    if (h_done || g_done) begin
      h_done_cnt += int'(h_done);
      g_done_cnt += int'(g_done);
      if (h_done && g_done) begin
        errors++;
        $display("FAIL done_both: h_done=%0b g_done=%0b, required only one", h_done, g_done);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: h_done=%0b g_done=%0b, required no done", h_done, g_done);
      end else begin
        e = exp_q.pop_front();
        if (g_done !== e.gc || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
          errors++;
          $display("FAIL done_resp: gc=%0b rdata=%h err=%0b, required gc=%0b rdata=%h err=%0b",
                   g_done, rsp_rdata, rsp_err, e.gc, e.rdata, e.err);
        end
      end
    end else if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL idle_rsp: rdata=%h err=%0b, required 0 0", rsp_rdata, rsp_err);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({h_gnt, g_gnt, h_done, g_done, f_valid, f_we, rsp_err} !== 7'd0 ||
        f_addr !== '0 || f_wdata !== 32'd0 || rsp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: ctl=%b addr=%h wdata=%h rdata=%h, required all 0",
               {h_gnt, g_gnt, h_done, g_done, f_valid, f_we, rsp_err}, f_addr, f_wdata, rsp_rdata);
    end
    tick;
    tick;
    rst = 1'b0;
    tick;
    checks++;
    if (f_valid !== 1'b0 || h_gnt !== 1'b0 || g_gnt !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: f_valid=%0b h_gnt=%0b g_gnt=%0b, required 0 0 0", f_valid, h_gnt, g_gnt);
    end
  endtask

  task automatic test_host_write;
    int d0 = h_done_cnt;
    h_req = 1'b1; h_we = 1'b1; h_addr = 16'h0010; h_wdata = 32'hDEADBEEF;
    f_ready = 1'b1;
    exp_q.push_back(exp_t'{gc: 1'b0, rdata: 32'd0, err: 1'b0});
    tick;
    h_req = 1'b0; h_wdata = 32'h0;
    checks++;
    if (h_gnt !== 1'b1 || g_gnt !== 1'b0 || f_valid !== 1'b1 || f_we !== 1'b1 ||
        f_addr !== 16'h0010 || f_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL hw_issue: gnt=%0b%0b valid=%0b we=%0b addr=%h wdata=%h, required 10 1 1 0010 deadbeef",
               h_gnt, g_gnt, f_valid, f_we, f_addr, f_wdata);
    end
    tick;
    f_ready = 1'b0;
    checks++;
    if (h_gnt !== 1'b0 || f_valid !== 1'b0) begin
      errors++;
      $display("FAIL hw_accept: h_gnt=%0b f_valid=%0b, required 0 0", h_gnt, f_valid);
    end
    tick;
    f_done = 1'b1; f_rdata = 32'hAAAA5555;
    tick;
    f_done = 1'b0;
    checks++;
    if (h_done !== 1'b1) begin
      errors++;
      $display("FAIL hw_done: h_done=%0b, required 1", h_done);
    end
    tick;
    tick;
    checks++;
    if (h_done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL hw_done_count: got %0d, required 1", h_done_cnt - d0);
    end
  endtask

  task automatic test_gc_read;
    g_req = 1'b1; g_we = 1'b0; g_addr = 16'h0200; g_wdata = 32'h0;
    f_ready = 1'b1; f_done = 1'b1; f_rdata = 32'h12345678;
    exp_q.push_back(exp_t'{gc: 1'b1, rdata: 32'h12345678, err: 1'b0});
    tick;
    g_req = 1'b0;
    checks++;
    if (g_gnt !== 1'b1 || h_gnt !== 1'b0 || f_addr !== 16'h0200 || f_we !== 1'b0) begin
      errors++;
      $display("FAIL gr_issue: g_gnt=%0b h_gnt=%0b addr=%h we=%0b, required 1 0 0200 0",
               g_gnt, h_gnt, f_addr, f_we);
    end
    tick;
    checks++;
    if (g_done !== 1'b0) begin
      errors++;
      $display("FAIL gr_early_done: g_done=%0b, required 0", g_done);
    end
    tick;
    checks++;
    if (g_done !== 1'b1 || h_done !== 1'b0) begin
      errors++;
      $display("FAIL gr_latency: g_done=%0b h_done=%0b, required 1 0", g_done, h_done);
    end
    f_ready = 1'b0; f_done = 1'b0;
    tick;
  endtask

  task automatic test_starvation;
    int   ng = 0;
    logic exp_gc;
    h_req = 1'b1; h_we = 1'b0; h_addr = 16'h0101;
    g_req = 1'b1; g_we = 1'b0; g_addr = 16'h0202;
    f_ready = 1'b1; f_done = 1'b1; f_rdata = 32'hCAFE0000;
    for (int c = 0; c < 200 && ng < 10; c++) begin
      tick;
      if (h_gnt || g_gnt) begin
        exp_gc = (ng % 5 == 4);
        checks++;
        if (g_gnt !== exp_gc || h_gnt !== !exp_gc) begin
          errors++;
          $display("FAIL grant_order[%0d]: h=%0b g=%0b, required h=%0b g=%0b",
                   ng, h_gnt, g_gnt, !exp_gc, exp_gc);
        end
        exp_q.push_back(exp_t'{gc: exp_gc, rdata: 32'hCAFE0000, err: 1'b0});
        ng++;
      end
    end
    checks++;
    if (ng != 10) begin
      errors++;
      $display("FAIL grant_count: got %0d, required 10", ng);
    end
    h_req = 1'b0; g_req = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick;
    f_ready = 1'b0; f_done = 1'b0;
    tick;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL starve_drain: %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_timeout;
    int early = 0;
    h_req = 1'b1; h_we = 1'b0; h_addr = 16'h0033;
    f_ready = 1'b0; f_done = 1'b0;
    exp_q.push_back(exp_t'{gc: 1'b0, rdata: 32'd0, err: 1'b1});
    tick;
    h_req = 1'b0;
    for (int k = 1; k < 16; k++) begin
      tick;
      if (f_valid !== 1'b1 || h_done !== 1'b0) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL to_hold: %0d early cycles, required 0", early);
    end
    tick;
    checks++;
    if (h_done !== 1'b1 || f_valid !== 1'b0 || rsp_err !== 1'b1 || rsp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL to_abort: done=%0b valid=%0b err=%0b rdata=%h, required 1 0 1 0",
               h_done, f_valid, rsp_err, rsp_rdata);
    end
    tick;
  endtask

  task automatic test_done_beats_timeout;
    h_req = 1'b1; h_we = 1'b0; h_addr = 16'h0077;
    f_ready = 1'b0; f_done = 1'b0;
    exp_q.push_back(exp_t'{gc: 1'b0, rdata: 32'h0BADF00D, err: 1'b0});
    tick;
    h_req = 1'b0;
    for (int k = 1; k < 14; k++) tick;
    f_ready = 1'b1;
    tick;
    f_ready = 1'b0;
    tick;
    checks++;
    if (h_done !== 1'b0 || f_valid !== 1'b0) begin
      errors++;
      $display("FAIL dbt_wait: h_done=%0b f_valid=%0b, required 0 0", h_done, f_valid);
    end
    f_done = 1'b1; f_rdata = 32'h0BADF00D;
    tick;
    f_done = 1'b0;
    checks++;
    if (h_done !== 1'b1 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL dbt_done: h_done=%0b rsp_err=%0b, required 1 0", h_done, rsp_err);
    end
    tick;
  endtask

  task automatic test_reset_in_wait;
    int d0 = h_done_cnt;
    h_req = 1'b1; h_we = 1'b1; h_addr = 16'h0ABC; h_wdata = 32'h11112222;
    f_ready = 1'b1;
    tick;
    h_req = 1'b0;
    tick;
    f_ready = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if ({h_gnt, g_gnt, h_done, g_done, f_valid, f_we, rsp_err} !== 7'd0 ||
        f_addr !== '0 || f_wdata !== 32'd0 || rsp_rdata !== 32'd0) begin
      errors++;
      $display("FAIL rst_wait_outputs: ctl=%b addr=%h wdata=%h, required all 0",
               {h_gnt, g_gnt, h_done, g_done, f_valid, f_we, rsp_err}, f_addr, f_wdata);
    end
    f_done = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    f_done = 1'b0;
    tick;
    tick;
    checks++;
    if (h_done_cnt != d0) begin
      errors++;
      $display("FAIL rst_no_done: %0d dones, required 0", h_done_cnt - d0);
    end
    h_req = 1'b1; h_we = 1'b0; h_addr = 16'h0044;
    f_ready = 1'b1; f_done = 1'b1; f_rdata = 32'h55AA55AA;
    exp_q.push_back(exp_t'{gc: 1'b0, rdata: 32'h55AA55AA, err: 1'b0});
    tick;
    h_req = 1'b0;
    checks++;
    if (h_gnt !== 1'b1 || f_addr !== 16'h0044) begin
      errors++;
      $display("FAIL rst_after_issue: h_gnt=%0b addr=%h, required 1 0044", h_gnt, f_addr);
    end
    tick;
    tick;
    checks++;
    if (h_done !== 1'b1 || rsp_rdata !== 32'h55AA55AA) begin
      errors++;
      $display("FAIL rst_after_done: h_done=%0b rdata=%h, required 1 55aa55aa", h_done, rsp_rdata);
    end
    f_ready = 1'b0; f_done = 1'b0;
    tick;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_drain: %0d pending, required 0", exp_q.size());
    end
  endtask

  initial begin
    rst = 1'b0;
    h_req = 1'b0; h_we = 1'b0; h_addr = '0; h_wdata = 32'd0;
    g_req = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = 32'd0;
    f_ready = 1'b0; f_done = 1'b0; f_rdata = 32'd0;
    test_reset;
    test_host_write;
    test_gc_read;
    test_starvation;
    test_timeout;
    test_done_beats_timeout;
    test_reset_in_wait;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
